// File: rtl/arb_pkg.sv
// Shared types and defaults for the RAM arbiter slice.
//   owner_e     : read-return / last-grant owner (NONE, CPU, LDR)
//   arb_state_e : arbitration mode (RR, LOCKED)
//   ARB_ADDR_W / ARB_DATA_W : default RAM geometry used by the CPU top and RAM
//   WAIT_W      : width of the starvation counter (MAX_WAIT up to 15)
//   CONF_W      : width of the saturating conflict counter
package arb_pkg;

   localparam int unsigned ARB_ADDR_W = 8;
   localparam int unsigned ARB_DATA_W = 16;
   localparam int unsigned WAIT_W     = 4;
   localparam int unsigned CONF_W     = 8;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      CPU  = 2'd1,
      LDR  = 2'd2
   } owner_e;

   typedef enum logic {
      RR     = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/ram_arbiter_wait_counter.sv
// Starvation counter for the loader burst lock.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr_i  : clear count (wins over increment)
//   inc_i  : count one more CPU-denied cycle
//   hit_o  : count has reached MAX_WAIT
module ram_arbiter_wait_counter
   import arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic hit_o
);

   localparam logic [WAIT_W-1:0] MAX_C = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] cnt_q;
   logic [WAIT_W-1:0] cnt_d;

   assign hit_o = (cnt_q == MAX_C);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !hit_o) begin
         cnt_d = cnt_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of the single-port instruction/data RAM.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    : CPU access request
//   cpu_gnt                  : CPU access issued this cycle
//   cpu_rvalid/rdata         : CPU read response (one cycle after grant)
//   ldr_req/we/lock/addr/wdata : loader request and burst lock
//   ldr_gnt                  : loader access issued this cycle
//   ldr_rvalid/rdata         : loader read response
//   ram_w_en, ram_r_addr, ram_w_addr, ram_w_data : RAM drive (granted access)
//   ram_r_data               : RAM read data, one cycle after address
//   conflict_cnt             : saturating count of cycles with both requesting
module ram_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = ARB_ADDR_W,
   parameter int unsigned DATA_W   = ARB_DATA_W,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic              ldr_lock,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ram_w_en,
   output logic [ADDR_W-1:0] ram_r_addr,
   output logic [ADDR_W-1:0] ram_w_addr,
   output logic [DATA_W-1:0] ram_w_data,
   input  logic [DATA_W-1:0] ram_r_data,
   output logic [CONF_W-1:0] conflict_cnt
);

   arb_state_e        state_q, state_d;
   owner_e            last_owner_q, last_owner_d;
   owner_e            rd_owner_q, rd_owner_d;
   logic [DATA_W-1:0] cpu_rdata_q, ldr_rdata_q;
   logic [CONF_W-1:0] conf_q;

   logic cpu_win, ldr_win;
   logic wait_hit, wait_inc, wait_clr;

   ram_arbiter_wait_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait (
      .clk_i (clk),
      .rst_i (rst),
      .clr_i (wait_clr),
      .inc_i (wait_inc),
      .hit_o (wait_hit)
   );

   // Grant selection
   always_comb begin
      cpu_win = 1'b0;
      ldr_win = 1'b0;
      if (state_q == RR) begin
         if (cpu_req && ldr_req) begin
            if (last_owner_q == LDR) cpu_win = 1'b1;
            else                     ldr_win = 1'b1;
         end else begin
            cpu_win = cpu_req;
            ldr_win = ldr_req;
         end
      end else begin
         if (ldr_req) begin
            // Starvation guard overrides the lock for exactly one cycle.
            if (cpu_req && wait_hit) cpu_win = 1'b1;
            else                     ldr_win = 1'b1;
         end else begin
            cpu_win = cpu_req;
         end
      end
   end

   // Outputs, RAM drive and next state
   always_comb begin
      cpu_gnt      = cpu_win & ~rst;
      ldr_gnt      = ldr_win & ~rst;
      ram_w_en     = 1'b0;
      ram_r_addr   = '0;
      ram_w_addr   = '0;
      ram_w_data   = '0;
      state_d      = state_q;
      last_owner_d = last_owner_q;
      rd_owner_d   = NONE;

      if (cpu_gnt) begin
         ram_w_en     = cpu_we;
         ram_r_addr   = cpu_addr;
         ram_w_addr   = cpu_addr;
         ram_w_data   = cpu_wdata;
         last_owner_d = CPU;
         if (!cpu_we) rd_owner_d = CPU;
      end else if (ldr_gnt) begin
         ram_w_en     = ldr_we;
         ram_r_addr   = ldr_addr;
         ram_w_addr   = ldr_addr;
         ram_w_data   = ldr_wdata;
         last_owner_d = LDR;
         if (!ldr_we) rd_owner_d = LDR;
      end

      unique case (state_q)
         RR:      if (ldr_gnt && ldr_lock) state_d = LOCKED;
         LOCKED:  if (!ldr_lock)           state_d = RR;
         default: state_d = RR;
      endcase

      // The counter only lives while locked; leaving LOCKED starts the next
      // burst with a fresh budget.
      wait_inc = (state_q == LOCKED) && cpu_req && !cpu_gnt;
      wait_clr = cpu_gnt || (state_d == RR);

      cpu_rvalid = ~rst && (rd_owner_q == CPU);
      ldr_rvalid = ~rst && (rd_owner_q == LDR);
      cpu_rdata  = rst ? '0 : (cpu_rvalid ? ram_r_data : cpu_rdata_q);
      ldr_rdata  = rst ? '0 : (ldr_rvalid ? ram_r_data : ldr_rdata_q);
   end

   assign conflict_cnt = conf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RR;
         last_owner_q <= LDR;
         rd_owner_q   <= NONE;
         cpu_rdata_q  <= '0;
         ldr_rdata_q  <= '0;
         conf_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         rd_owner_q   <= rd_owner_d;
         if (rd_owner_q == CPU) cpu_rdata_q <= ram_r_data;
         if (rd_owner_q == LDR) ldr_rdata_q <= ram_r_data;
         if (cpu_req && ldr_req && (conf_q != '1)) conf_q <= conf_q + 1'b1;
      end
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port instruction/data RAM between the CPU (fetch and load/store through its address mux) and a loader/debug master that preloads programs and inspects memory. Sits between both masters and the RAM instance, drives the RAM address, write-enable and write-data, and routes the one-cycle-latency read data back to the correct owner. Round-robin on contention, with a loader burst lock bounded by a CPU starvation guard.

## Interface
- ADDR_W, 8, RAM address width.
- DATA_W, 16, RAM data width.
- MAX_WAIT, 4, maximum consecutive cycles the CPU may be denied while the loader lock is held; range 1..15.
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req / cpu_we  in  1 / 1  CPU access request and write flag.
- cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address and write data.
- cpu_gnt  out  1  CPU access issued this cycle.
- cpu_rvalid / cpu_rdata  out  1 / DATA_W  CPU read response.
- ldr_req / ldr_we / ldr_lock  in  1 / 1 / 1  loader request, write flag, burst lock.
- ldr_addr / ldr_wdata  in  ADDR_W / DATA_W  loader address and write data.
- ldr_gnt  out  1  loader access issued this cycle.
- ldr_rvalid / ldr_rdata  out  1 / DATA_W  loader read response.
- ram_w_en  out  1  RAM write strobe.
- ram_r_addr / ram_w_addr  out  ADDR_W  RAM addresses, both driven with the granted address.
- ram_w_data  out  DATA_W  RAM write data.
- ram_r_data  in  DATA_W  RAM read data, valid one cycle after address.
- conflict_cnt  out  8  saturating count of cycles with both requests asserted.

## Operation
- Requesters hold req/we/addr/wdata stable until their gnt; one access per grant.
- gnt is combinational from current req and registered state; at most one gnt per cycle.
- Granted access drives ram_r_addr = ram_w_addr = addr, ram_w_en = gnt & we, ram_w_data = wdata. No grant: addresses, data and ram_w_en driven 0.
- States RR and LOCKED.
- RR: a single requester wins. Both requesting: the master not granted most recently wins (last_owner). Loader granted with ldr_lock=1 -> LOCKED.
- LOCKED: loader wins whenever ldr_req=1. A CPU-denied cycle increments wait_cnt. When wait_cnt == MAX_WAIT and cpu_req=1, the CPU is granted, the loader is denied that cycle, and wait_cnt clears. wait_cnt also clears on any CPU grant. A cycle with ldr_req=0 grants a pending CPU request normally. ldr_lock sampled 0 at a clock edge -> RR.
- last_owner updates on every grant.
- Read grant records owner in rd_owner (NONE/CPU/LDR). Next cycle asserts that owner's rvalid with rdata = ram_r_data. The other port's rdata is held at its last value.
- Writes produce no rvalid.
- conflict_cnt increments on cpu_req & ldr_req and saturates at 255.

## Timing
- Read latency: gnt in cycle N, rvalid/rdata in cycle N+1; back-to-back reads by either master are allowed every cycle.
- Write completes at the edge ending the gnt cycle; a read of the same address granted in the next cycle returns the new data.
- Reset: state RR, last_owner = LDR (CPU wins the first tie), rd_owner NONE, wait_cnt 0, conflict_cnt 0.
- Outputs under reset: all gnt, rvalid, rdata, ram_w_en and addresses 0.
- Reset asserted mid-read suppresses the pending rvalid.
- ldr_lock asserted without a loader grant does not enter LOCKED.
- ldr_lock dropped in the same cycle as a CPU grant in LOCKED -> next state RR, last_owner = CPU.

## Structure
- Shared package arb_pkg holds owner_e (NONE, CPU, LDR), arb_state_e (RR, LOCKED), and the ADDR_W/DATA_W defaults used by the CPU top and RAM.
- One natural sub-module is wait_counter: the MAX_WAIT starvation counter with clear/increment/hit.
- Grant logic, read-return routing and conflict counter stay in ram_arbiter.

## Test plan
- CPU-only read of addr 0x10 holding 0xBEEF -> cpu_gnt cycle N, cpu_rvalid=1 and cpu_rdata=0xBEEF at N+1, ldr_rvalid stays 0.
- Both request continuously from reset -> grants alternate CPU, LDR, CPU, LDR; conflict_cnt = 4 after 4 cycles.
- Loader writes 0x1234 to 0x20, CPU reads 0x20 next cycle -> cpu_rdata=0x1234.
- Loader lock burst with CPU requesting, MAX_WAIT=4 -> 4 loader grants, then 1 CPU grant, then loader grants resume; drop ldr_lock -> alternation resumes.
- Reset asserted in the cycle after a loader read grant -> ldr_rvalid stays 0, all outputs 0, first post-reset tie goes to CPU.
- Hold both requests 300 cycles -> conflict_cnt saturates at 255.
